// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-system types.
//   lc3b_word      : 16-bit address / data word
//   lc3b_line      : 128-bit cache line
//   lc3b_arb_state : state of the I/D cache arbiter that shares physical memory
package cache_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    arb_idle,
    arb_grant_i,
    arb_grant_d
  } lc3b_arb_state;

endpackage

// File: rtl/cache_arbiter_control.sv
// State register and next-state logic of the cache arbiter.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   i_req      : I-cache wants the memory port
//   d_req      : D-cache wants the memory port (read or write)
//   pmem_resp  : physical memory finished the current transaction
//   state      : current arbiter state, decoded by the top level into muxes
module cache_arbiter_control
  import cache_arbiter_pkg::*;
#(
  parameter bit FIRST_TIE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          d_req,
  input  logic          pmem_resp,
  output lc3b_arb_state state
);

  lc3b_arb_state state_q;
  // 1 when the D-side held the most recent grant; a tie goes to the other side.
  logic          last_d;

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= arb_idle;
      // Pretend the side that must lose the first tie was granted last.
      last_d  <= !FIRST_TIE;
    end else begin
      case (state_q)
        arb_idle: begin
          if (d_req && (!i_req || !last_d)) begin
            state_q <= arb_grant_d;
            last_d  <= 1'b1;
          end else if (i_req) begin
            state_q <= arb_grant_i;
            last_d  <= 1'b0;
          end
        end
        // A grant is held until memory answers, whatever the requester does;
        // returning through IDLE guarantees a gap cycle between grants.
        arb_grant_i, arb_grant_d: begin
          if (pmem_resp) begin
            state_q <= arb_idle;
          end
        end
        default: state_q <= arb_idle;
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbiter sharing one physical memory port between the I-cache and D-cache.
//   clk, rst                         : clock, asynchronous active-high reset
//   i_pmem_read / i_pmem_address     : I-cache line fill request
//   i_pmem_rdata / i_pmem_resp       : fill data and completion to the I-cache
//   d_pmem_read / d_pmem_write       : D-cache fill / writeback request
//   d_pmem_address / d_pmem_wdata    : D-cache line address and writeback line
//   d_pmem_rdata / d_pmem_resp       : fill data and completion to the D-cache
//   pmem_read / pmem_write           : command to physical memory
//   pmem_address / pmem_wdata        : address and write line to physical memory
//   pmem_rdata / pmem_resp           : read line and completion from memory
// FIRST_TIE picks the winner of the first simultaneous request (1 = D, 0 = I).
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter bit FIRST_TIE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pmem_read,
  input  logic [15:0]  i_pmem_address,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  lc3b_arb_state state;

  cache_arbiter_control #(
    .FIRST_TIE (FIRST_TIE)
  ) u_control (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_pmem_read),
    .d_req     (d_pmem_read | d_pmem_write),
    .pmem_resp (pmem_resp),
    .state     (state)
  );

  // Read data needs no steering: only the granted side sees a resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state)
      arb_grant_i: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      arb_grant_d: begin
        // Read and write together is resolved as a writeback.
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam bit FIRST_TIE = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_pmem_read = 1'b0;
  logic [15:0]  i_pmem_address = '0;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [15:0]  d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  cache_arbiter #(.FIRST_TIE(FIRST_TIE)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    logic         wr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } txn_t;

  txn_t qi[$];
  txn_t qd[$];
  int   grant_log[$];   // 0 = I-side grant, 1 = D-side grant
  int   checks = 0;
  int   errors = 0;

  // Memory / requester state
  bit           mem_en = 1'b0;
  int           mem_cnt = 0;
  int           mem_lat = 1;
  int           lat_fix = 0;
  bit           rd_ovr_en = 1'b0;
  logic [127:0] rd_ovr = '0;
  bit           auto_req = 1'b0;
  bit           i_busy = 1'b0;
  bit           d_busy = 1'b0;
  logic         i_done = 1'b0;
  logic         d_done = 1'b0;
  int           i_resp_cnt = 0;
  int           d_resp_cnt = 0;
  logic [127:0] last_i_rdata = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_data(input logic [15:0] a);
    return {4{a, a ^ 16'h9E37}};
  endfunction

  task automatic issue_i(input logic [15:0] a, input logic [127:0] rd);
    txn_t t;
    t.addr = a; t.wr = 1'b0; t.wdata = '0; t.rdata = rd;
    qi.push_back(t);
    i_pmem_address = a;
    i_pmem_read    = 1'b1;
    i_busy         = 1'b1;
  endtask

  task automatic issue_d(input logic [15:0] a, input logic rd_b, input logic wr_b,
                         input logic [127:0] wd, input logic [127:0] rd);
    txn_t t;
    t.addr = a; t.wr = wr_b; t.wdata = wd; t.rdata = rd;
    qd.push_back(t);
    d_pmem_address = a;
    d_pmem_wdata   = wd;
    d_pmem_read    = rd_b;
    d_pmem_write   = wr_b;
    d_busy         = 1'b1;
  endtask

  // Memory: answers any visible command after mem_lat cycles.
  task automatic mem_step();
    logic cmd;
    cmd = pmem_read | pmem_write;
    pmem_resp  = 1'b0;
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (cmd) begin
      if (mem_cnt == 0) mem_lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rd_ovr_en ? rd_ovr : mem_data(pmem_address);
        mem_cnt    = 0;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic rand_req();
    logic [15:0]  a;
    logic [127:0] wd;
    int           k;
    if (!i_busy && !i_done && $urandom_range(0, 2) == 0) begin
      a = {1'b0, 15'($urandom)};
      issue_i(a, mem_data(a));
    end
    if (!d_busy && !d_done && $urandom_range(0, 2) == 0) begin
      a  = {1'b1, 15'($urandom)};
      wd = {$urandom, $urandom, $urandom, $urandom};
      k  = $urandom_range(0, 2);   // 0 read, 1 write, 2 both
      issue_d(a, k != 1, k != 0, wd, mem_data(a));
    end
  endtask

  // One clock: note responses at the falling edge, then act after the rising edge.
  task automatic tick();
    @(negedge clk);
    i_done = i_pmem_resp;
    d_done = d_pmem_resp;
    if (i_done) begin i_resp_cnt++; last_i_rdata = i_pmem_rdata; end
    if (d_done) d_resp_cnt++;
    @(posedge clk);
    #1;
    if (i_done) begin i_pmem_read = 1'b0; i_busy = 1'b0; end
    if (d_done) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_busy = 1'b0; end
    if (mem_en) mem_step();
    if (auto_req) rand_req();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((i_busy || d_busy) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_complete"}, {126'd0, i_busy, d_busy}, '0);
  endtask

  // Monitor / scoreboard with the arbitration reference model.
  logic prev_cmd = 1'b0;
  logic prev_ri = 1'b0;
  logic prev_rd = 1'b0;
  bit   prev_ok = 1'b0;
  int   last_side = 0;
  int   pred = 0;

  always @(negedge clk) begin
    logic cmd;
    int   w;
    txn_t t;
    cmd = pmem_read | pmem_write;
    if (rst) begin
      last_side = FIRST_TIE ? 0 : 1;
      prev_ok   = 1'b0;
      prev_cmd  = 1'b0;
    end else begin
      // A request seen in an idle cycle must become a command one cycle later.
      if (prev_ok && !prev_cmd && (prev_ri || prev_rd)) begin
        check("latency", {127'd0, cmd}, 128'd1);
        w = (prev_ri && prev_rd) ? 1 - last_side : (prev_rd ? 1 : 0);
        last_side = w;
        pred      = w;
        grant_log.push_back(w);
        if ((w == 1 && qd.size() > 0) || (w == 0 && qi.size() > 0)) begin
          t = (w == 1) ? qd[0] : qi[0];
          check("grant_addr", {112'd0, pmem_address}, {112'd0, t.addr});
          check("grant_write", {127'd0, pmem_write}, {127'd0, t.wr});
          check("grant_read", {127'd0, pmem_read}, {127'd0, !t.wr});
          check("grant_wdata", pmem_wdata, (w == 1) ? t.wdata : '0);
        end else begin
          check("grant_expected", 128'd0, 128'd1);
        end
      end
      if (pmem_resp && cmd) begin
        check("resp_i", {127'd0, i_pmem_resp}, {127'd0, pred == 0});
        check("resp_d", {127'd0, d_pmem_resp}, {127'd0, pred == 1});
        if (pred == 0 && qi.size() > 0) begin
          t = qi.pop_front();
          check("rdata_i", i_pmem_rdata, t.rdata);
        end else if (pred == 1 && qd.size() > 0) begin
          t = qd.pop_front();
          if (t.wr) check("wb_data", pmem_wdata, t.wdata);
          else      check("rdata_d", d_pmem_rdata, t.rdata);
        end
      end else if (pmem_resp || i_pmem_resp || d_pmem_resp) begin
        check("resp_gate", {126'd0, i_pmem_resp, d_pmem_resp}, '0);
      end
      prev_cmd = cmd;
      prev_ri  = i_pmem_read;
      prev_rd  = d_pmem_read | d_pmem_write;
      prev_ok  = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt_before;
    logic rd_bad;

    // Reset state: outputs quiet, stray resp not forwarded, rdata passes through.
    pmem_resp  = 1'b1;
    pmem_rdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    tick();
    check("rst_pmem_read", {127'd0, pmem_read}, '0);
    check("rst_pmem_write", {127'd0, pmem_write}, '0);
    check("rst_pmem_address", {112'd0, pmem_address}, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_resp", {126'd0, i_pmem_resp, d_pmem_resp}, '0);
    check("rdata_pass_i", i_pmem_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    check("rdata_pass_d", d_pmem_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    pmem_resp = 1'b0;
    rst = 1'b0;
    tick();

    // Single I read, memory answers on the third grant cycle with 'hA5.
    mem_en = 1'b1; lat_fix = 3; rd_ovr_en = 1'b1; rd_ovr = 128'hA5;
    i_resp_cnt = 0; d_resp_cnt = 0;
    issue_i(16'h1230, 128'hA5);
    tick();
    check("t1_pmem_read", {127'd0, pmem_read}, 128'd1);
    check("t1_pmem_address", {112'd0, pmem_address}, 128'h1230);
    wait_idle("t1");
    check("t1_i_resp_count", i_resp_cnt, 1);
    check("t1_d_resp_count", d_resp_cnt, 0);
    check("t1_i_rdata", last_i_rdata, 128'hA5);
    rd_ovr_en = 1'b0;

    // Simultaneous reads after reset: D, then I, then I beats a new D request.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    lat_fix = 0;
    grant_log.delete();
    issue_i(16'h0100, mem_data(16'h0100));
    issue_d(16'h8200, 1'b1, 1'b0, 128'h5555, mem_data(16'h8200));
    n = 0;
    while (d_busy && n < 50) begin tick(); n++; end
    issue_d(16'h8300, 1'b1, 1'b0, 128'h6666, mem_data(16'h8300));
    wait_idle("t2");
    check("t2_grants", grant_log.size(), 3);
    check("t2_first_d", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    check("t2_second_i", (grant_log.size() > 1) ? grant_log[1] : -1, 0);
    check("t2_third_d", (grant_log.size() > 2) ? grant_log[2] : -1, 1);

    // D writeback while I waits (last grant was D, so issue D alone first).
    lat_fix = 2;
    grant_log.delete();
    issue_d(16'h4440, 1'b0, 1'b1, 128'hDEAD, mem_data(16'h4440));
    tick();
    check("t3_pmem_write", {127'd0, pmem_write}, 128'd1);
    check("t3_pmem_wdata", pmem_wdata, 128'hDEAD);
    issue_i(16'h1230, mem_data(16'h1230));
    rd_bad = 1'b0;
    n = 0;
    while (d_busy && n < 50) begin
      rd_bad = rd_bad | pmem_read;
      tick();
      n++;
    end
    check("t3_read_low", {127'd0, rd_bad}, '0);
    wait_idle("t3");
    check("t3_order_d", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    check("t3_order_i", (grant_log.size() > 1) ? grant_log[1] : -1, 0);

    // Read and write together is a write.
    issue_d(16'h8010, 1'b1, 1'b1, 128'hBEEF_0001, mem_data(16'h8010));
    tick();
    check("t4_write", {127'd0, pmem_write}, 128'd1);
    check("t4_read", {127'd0, pmem_read}, '0);
    wait_idle("t4");

    // Reset in the middle of an I grant, then a late memory resp.
    mem_en = 1'b0; pmem_resp = 1'b0;
    cnt_before = i_resp_cnt;
    issue_i(16'h2220, mem_data(16'h2220));
    tick(); tick();
    check("t5_granted", {127'd0, pmem_read}, 128'd1);
    rst = 1'b1;
    #1;
    check("t5_abort_read", {127'd0, pmem_read}, '0);
    check("t5_abort_address", {112'd0, pmem_address}, '0);
    qi.delete();
    i_pmem_read = 1'b0; i_busy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    tick();
    check("t5_no_resp", i_resp_cnt, cnt_before);
    check("t5_stays_idle", {126'd0, pmem_read, pmem_write}, '0);

    // Stray resp in IDLE with nothing requested.
    pmem_resp = 1'b1;
    #1;
    check("t6_stray", {126'd0, i_pmem_resp, d_pmem_resp}, '0);
    tick();
    pmem_resp = 1'b0;
    tick();
    check("t6_idle", {126'd0, pmem_read, pmem_write}, '0);

    // Randomised traffic against the scoreboard.
    mem_en = 1'b1; lat_fix = 0;
    grant_log.delete();
    auto_req = 1'b1;
    repeat (3000) tick();
    auto_req = 1'b0;
    wait_idle("rand");
    repeat (3) tick();
    check("rand_qi_empty", qi.size(), 0);
    check("rand_qd_empty", qd.size(), 0);
    check("rand_enough_grants", {127'd0, grant_log.size() > 100}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
